kernel_arbiter: RTL and testbench
=================================

# kernel_arbiter

Round-robin arbiter and sequencer that shares one combinational 4-bit→24-bit datapath kernel among `NUM_REQ` requesters. Each requester presents a 4-bit operand through a valid/ready handshake. The block registers the winning operand onto the kernel input and waits a fixed settle time. It then captures the 24-bit kernel result and returns it with the requester's ID through a valid/ready response port. The block sits between the request fabric and the single kernel instance; the kernel stays outside it and connects through `kern_in`/`kern_out`.

## Interface
- `NUM_REQ`, 4 — number of requesters; legal range ≥2.
- `IN_W`, 4 — operand width.
- `OUT_W`, 24 — result width.
- `KERNEL_LAT`, 1 — cycles the kernel input is held before capture; legal range ≥1.
- `ID_W`, `$clog2(NUM_REQ)` — derived; not overridden.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_data`  in  NUM_REQ*IN_W  operands; requester i in bits [i*IN_W +: IN_W].
- `kern_in`  out  IN_W  registered operand to the kernel.
- `kern_out`  in  OUT_W  kernel result, combinational in `kern_in`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accept.
- `rsp_data`  out  OUT_W  captured result.
- `rsp_id`  out  ID_W  index of the requester that produced `rsp_data`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EVAL, RESP.
- **IDLE**
  - Round-robin pick among `req_valid`, searching upward from `rr_ptr` and wrapping at `NUM_REQ-1`→0.
  - `req_ready[g]`=1 for the winner g only; this output is combinational from `req_valid`, `rr_ptr` and state.
  - On the accept edge: `kern_in`←`req_data[g]`, `id_q`←g, `rr_ptr`←(g+1) mod `NUM_REQ`, `lat_cnt`←`KERNEL_LAT-1`, state→EVAL.
  - With no valid requester, the block stays in IDLE and `rr_ptr` is unchanged.
- **EVAL**
  - All `req_ready`=0; `kern_in` held.
  - If `lat_cnt`≠0: decrement.
  - If `lat_cnt`=0: `rsp_data`←`kern_out`, `rsp_id`←`id_q`, state→RESP.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_data`/`rsp_id` are held stable until `rsp_valid && rsp_ready`; on that edge the state goes to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- `kern_in` keeps its last value in IDLE and RESP; it does not return to zero.
- Width rules:
  - `rsp_data` is the kernel result unmodified: no truncation or extension.
  - `rr_ptr` wrap is explicit; there is no reliance on power-of-two `NUM_REQ`.
- Reset values: state=IDLE, `rr_ptr`=0, `kern_in`=0, `rsp_data`=0, `rsp_id`=0, `rsp_valid`=0, `req_ready`=0 (while `rst` is high), `busy`=0.
- Reset mid-operation aborts the transaction. No response is produced and the requester is not re-served unless it still asserts valid after reset.

## Timing
- Accept edge E0. `rsp_valid` rises after edge E0+`KERNEL_LAT`.
- The minimum cycle count from accept to the next accept is `KERNEL_LAT`+2 when `rsp_ready` is tied high.
- Each additional cycle of `rsp_ready` low adds one cycle; there is no drop and no overwrite.
- `req_valid` may drop without having been granted; no state is affected.
- Requester i's operand is sampled only on its own accept edge.

## Structure
- Package `kernel_arb_pkg`:
  - state enum `arb_state_e` {IDLE, EVAL, RESP}.
  - default constants `KERN_IN_W`=4 and `KERN_OUT_W`=24.
- Sub-module `rr_picker`: combinational. Inputs are the `NUM_REQ`-bit request vector and `rr_ptr`. Outputs are one-hot `grant`, `grant_idx` and `any`.
- The top level holds the FSM, `lat_cnt`, and the operand and response registers.

## Test plan
- **Bench kernel model:** `kern_out` = `kern_in`×24'h000101.
- **Single request:** req 2 valid with data 4'hA, `KERNEL_LAT`=1, `rsp_ready`=1.
  - Accept at E0.
  - `rsp_valid` high after E1 with `rsp_data`=24'h000A0A and `rsp_id`=2; IDLE after E2.
- **Fairness:** all 4 requesters valid continuously with data i+1.
  - Grant order 0,1,2,3,0.
  - Results are 24'h000101·(i+1); accepts are spaced 3 cycles apart.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - `rsp_data`/`rsp_id` stay stable and `req_ready` stays 0 throughout.
  - Release gives exactly one response handshake.
- **Latency parameter:** with `KERNEL_LAT`=3, data 4'hF → `rsp_valid` after E3 with `rsp_data`=24'h000F0F.
- **Reset mid-EVAL:** assert `rst` during EVAL.
  - All outputs go to their reset values immediately.
  - After release, req 1 valid → granted first because `rr_ptr`=0 and req 0 is idle.
- **Pointer wrap:** only req 3 then req 0 valid.
  - Grant 3, then 0.
  - `rr_ptr` reads 0 after the first grant and 1 after the second.

Source files
------------

// File: rtl/kernel_arbiter_pkg.sv
// Shared definitions for the kernel arbiter: FSM state encoding and the
// default operand/result widths of the shared datapath kernel.
package kernel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int KERN_IN_W  = 4;
  localparam int KERN_OUT_W = 24;

endpackage

// File: rtl/kernel_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Searches req_i upward starting at ptr_i, wrapping from NUM_REQ-1 to 0, and
// returns the first asserted requester.
//   req_i       : request vector
//   ptr_i       : index with highest priority this cycle
//   grant_o     : one-hot grant (zero when nothing requests)
//   grant_idx_o : binary index of the granted requester
//   any_o       : at least one requester is asserted
module rr_picker
  import kernel_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_o
);

  // One extra bit so ptr+offset cannot overflow before the explicit wrap;
  // NUM_REQ need not be a power of two.
  logic [ID_W:0] sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/kernel_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational kernel
// among NUM_REQ requesters. A granted operand is registered onto kern_in,
// held for KERNEL_LAT cycles, then the kernel result is captured and offered
// on a valid/ready response port together with the requester index.
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_data             : operands, requester i at [i*IN_W +: IN_W]
//   kern_in / kern_out   : registered kernel operand / kernel result
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data / rsp_id    : captured result and the index that produced it
//   busy                 : FSM is not in IDLE
module kernel_arbiter
  import kernel_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int IN_W       = KERN_IN_W,
  parameter  int OUT_W      = KERN_OUT_W,
  parameter  int KERNEL_LAT = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [IN_W-1:0]         kern_in,
  input  logic [OUT_W-1:0]        kern_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int LAT_W = (KERNEL_LAT > 1) ? $clog2(KERNEL_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(KERNEL_LAT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [IN_W-1:0]    kern_in_q, kern_in_d;
  logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [IN_W-1:0]    sel_op;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // Operand mux driven by the one-hot grant, constant part-selects only.
  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_data[i*IN_W +: IN_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    lat_cnt_d  = lat_cnt_q;
    kern_in_d  = kern_in_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          kern_in_d = sel_op;
          id_d      = grant_idx;
          rr_ptr_d  = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
          lat_cnt_d = LAT_LOAD;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end else begin
          rsp_data_d = kern_out;
          rsp_id_d   = id_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE first keeps a new accept out of the handshake cycle.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      lat_cnt_q  <= '0;
      kern_in_q  <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      lat_cnt_q  <= lat_cnt_d;
      kern_in_q  <= kern_in_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // Grant is offered only in IDLE, and never while reset is held.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign kern_in   = kern_in_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_kernel_arbiter.sv
`timescale 1ns/1ps
module tb_kernel_arbiter;

  localparam int N   = 4;
  localparam int IW  = 4;
  localparam int OW  = 24;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (KERNEL_LAT = 1)
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*IW-1:0] req_data;
  logic [IW-1:0] kern_in;
  logic [OW-1:0] kern_out;
  logic          rsp_valid, rsp_ready;
  logic [OW-1:0] rsp_data;
  logic [1:0]    rsp_id;
  logic          busy;

  assign kern_out = {20'd0, kern_in} * 24'h000101;

  kernel_arbiter #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW), .KERNEL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .kern_in(kern_in), .kern_out(kern_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy));

  // second DUT (KERNEL_LAT = 3)
  logic          rst3;
  logic [N-1:0]  rv3, rrdy3;
  logic [N*IW-1:0] rd3;
  logic [IW-1:0] kin3;
  logic [OW-1:0] kout3;
  logic          rspv3, rspr3;
  logic [OW-1:0] rspd3;
  logic [1:0]    rspid3;
  logic          busy3;

  assign kout3 = {20'd0, kin3} * 24'h000101;

  kernel_arbiter #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW), .KERNEL_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(rv3), .req_ready(rrdy3),
    .req_data(rd3), .kern_in(kin3), .kern_out(kout3),
    .rsp_valid(rspv3), .rsp_ready(rspr3), .rsp_data(rspd3),
    .rsp_id(rspid3), .busy(busy3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [23:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   dut_grants[$];
  int   dut_acc_cyc[$];
  int   hs_cnt = 0;

  // Reference model: plain round-robin over indices, one transaction at a time.
  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  bit           m_active = 1'b0;
  int           m_acc = 0;
  int           m_ptr = 0;
  logic [IW-1:0] m_op = '0;
  bit           m_ev;
  int           m_w;
  logic [N-1:0] m_onehot;
  exp_t         m_item;

  always @(negedge clk) begin
    if (rst) begin
      chk(req_ready == '0, "rst_req_ready", req_ready, 0);
      chk(rsp_valid == 1'b0, "rst_rsp_valid", rsp_valid, 0);
      chk(busy == 1'b0, "rst_busy", busy, 0);
      chk(kern_in == '0, "rst_kern_in", kern_in, 0);
      m_active = 1'b0;
      m_ptr    = 0;
    end else if (m_active) begin
      m_ev = (cyc >= m_acc + LAT);
      chk(req_ready == '0, "eval_req_ready", req_ready, 0);
      chk(rsp_valid == m_ev, "rsp_valid", rsp_valid, m_ev);
      chk(busy == 1'b1, "busy_active", busy, 1);
      chk(kern_in == m_op, "kern_in", kern_in, m_op);
      chk(int'(dut.rr_ptr_q) == m_ptr, "rr_ptr", dut.rr_ptr_q, m_ptr);
      if (m_ev && rsp_ready) m_active = 1'b0;
    end else begin
      m_w = rr_pick(req_valid, m_ptr);
      m_onehot = (m_w >= 0) ? (N'(1) << m_w) : '0;
      chk(req_ready == m_onehot, "req_ready", req_ready, m_onehot);
      chk(rsp_valid == 1'b0, "idle_rsp_valid", rsp_valid, 0);
      chk(busy == 1'b0, "idle_busy", busy, 0);
      chk(int'(dut.rr_ptr_q) == m_ptr, "rr_ptr", dut.rr_ptr_q, m_ptr);
      if (m_w >= 0) begin
        m_active    = 1'b1;
        m_acc       = cyc + 1;
        m_op        = req_data[m_w*IW +: IW];
        m_item.id   = 2'(m_w);
        m_item.data = 24'(m_op) * 24'h000101;
        exp_q.push_back(m_item);
        m_ptr = (m_w + 1) % N;
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head
  // and logs the grants the DUT actually issues.
  always @(negedge clk) begin
    if (!rst) begin
      if ((req_ready & req_valid) != '0) begin
        for (int j = 0; j < N; j++) if (req_ready[j]) dut_grants.push_back(j);
        dut_acc_cyc.push_back(cyc + 1);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "rsp_unexpected", rsp_data, 0);
        end else begin
          chk(rsp_data == exp_q[0].data, "rsp_data", rsp_data, exp_q[0].data);
          chk(rsp_id == exp_q[0].id, "rsp_id", rsp_id, exp_q[0].id);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int w);
    w = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != '0) begin
        for (int j = 0; j < N; j++) if (req_ready[j]) w = j;
        break;
      end
    end
    if (w < 0) chk(1'b0, "accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk(1'b0, "idle_timeout", 0, 1);
  endtask

  int w, base, hs0;
  int ord[5] = '{0, 1, 2, 3, 0};
  bit seen;

  initial begin
    rst = 1'b0; rst3 = 1'b0;
    req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    rv3 = '0; rd3 = '0; rspr3 = 1'b1;
    #1 rst = 1'b1; rst3 = 1'b1;
    #1;
    chk(rsp_valid == 1'b0, "por_rsp_valid", rsp_valid, 0);
    chk(rsp_data == '0, "por_rsp_data", rsp_data, 0);
    chk(rsp_id == '0, "por_rsp_id", rsp_id, 0);
    chk(kern_in == '0, "por_kern_in", kern_in, 0);
    chk(busy3 == 1'b0, "por_busy3", busy3, 0);
    step(2);
    rst = 1'b0; rst3 = 1'b0;

    // KERNEL_LAT = 3 instance: valid appears after E3
    rd3 = 16'h000F; rv3 = 4'b0001;
    @(negedge clk);
    chk(rrdy3 == 4'b0001, "lat3_ready", rrdy3, 1);
    @(posedge clk); #1;
    rv3 = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(rspv3 == (k == 3), "lat3_rsp_valid", rspv3, (k == 3));
      if (k == 3) begin
        chk(rspd3 == 24'h000F0F, "lat3_rsp_data", rspd3, 24'h000F0F);
        chk(rspid3 == 2'd0, "lat3_rsp_id", rspid3, 0);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk(busy3 == 1'b0, "lat3_idle", busy3, 0);
    @(posedge clk); #1;

    // Fairness: everyone requests, data i+1
    base = dut_grants.size();
    req_data = {4'd4, 4'd3, 4'd2, 4'd1};
    req_valid = 4'hF;
    step(16);
    req_valid = '0;
    wait_idle();
    chk(dut_grants.size() >= base + 5, "fair_count", dut_grants.size() - base, 5);
    if (dut_grants.size() >= base + 5) begin
      for (int i = 0; i < 5; i++)
        chk(dut_grants[base+i] == ord[i], "fair_order", dut_grants[base+i], ord[i]);
      for (int i = 0; i < 4; i++)
        chk(dut_acc_cyc[base+i+1] - dut_acc_cyc[base+i] == 3, "fair_spacing",
            dut_acc_cyc[base+i+1] - dut_acc_cyc[base+i], 3);
    end

    // Single request: req 2, data A
    req_data = 16'h0A00; req_valid = 4'b0100;
    wait_accept(w);
    req_valid = '0;
    chk(w == 2, "single_grant", w, 2);
    @(negedge clk);
    chk(rsp_valid == 1'b0, "single_e0", rsp_valid, 0);
    @(negedge clk);
    chk(rsp_valid == 1'b1, "single_e1_valid", rsp_valid, 1);
    chk(rsp_data == 24'h000A0A, "single_data", rsp_data, 24'h000A0A);
    chk(rsp_id == 2'd2, "single_id", rsp_id, 2);
    @(negedge clk);
    chk(busy == 1'b0, "single_e2_idle", busy, 0);
    @(posedge clk); #1;

    // Backpressure
    rsp_ready = 1'b0;
    req_data = 16'h0050; req_valid = 4'b0010;
    wait_accept(w);
    req_valid = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "bp_valid_seen", seen, 1);
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(rsp_valid == 1'b1, "bp_hold_valid", rsp_valid, 1);
      chk(rsp_data == 24'h000505, "bp_hold_data", rsp_data, 24'h000505);
      chk(req_ready == '0, "bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = '0;
    step(3);
    chk(hs_cnt == hs0 + 1, "bp_one_handshake", hs_cnt - hs0, 1);
    wait_idle();

    // Reset during EVAL
    req_data = 16'h0700; req_valid = 4'b0100;
    wait_accept(w);
    req_valid = '0;
    #1;
    chk(busy == 1'b1, "mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk(busy == 1'b0, "mid_rst_busy", busy, 0);
    chk(rsp_valid == 1'b0, "mid_rst_rsp_valid", rsp_valid, 0);
    chk(kern_in == '0, "mid_rst_kern_in", kern_in, 0);
    chk(rsp_data == '0, "mid_rst_rsp_data", rsp_data, 0);
    chk(rsp_id == '0, "mid_rst_rsp_id", rsp_id, 0);
    chk(req_ready == '0, "mid_rst_req_ready", req_ready, 0);
    exp_q.delete();
    step(2);
    rst = 1'b0;
    req_data = 16'h6090; req_valid = 4'b1010;
    wait_accept(w);
    req_valid = '0;
    chk(w == 1, "post_rst_grant", w, 1);
    wait_idle();

    // Pointer wrap: 3 then 0
    req_data = 16'h3000; req_valid = 4'b1000;
    wait_accept(w);
    req_valid = '0;
    chk(w == 3, "wrap_grant3", w, 3);
    @(negedge clk);
    chk(dut.rr_ptr_q == 2'd0, "wrap_ptr0", dut.rr_ptr_q, 0);
    @(posedge clk); #1;
    wait_idle();
    req_data = 16'h0008; req_valid = 4'b0001;
    wait_accept(w);
    req_valid = '0;
    chk(w == 0, "wrap_grant0", w, 0);
    @(negedge clk);
    chk(dut.rr_ptr_q == 2'd1, "wrap_ptr1", dut.rr_ptr_q, 1);
    @(posedge clk); #1;
    wait_idle();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      req_data  = 16'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      step(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    step(2);
    chk(exp_q.size() == 0, "sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
